capture_readout: RTL
====================

# capture_readout

Downstream stage of the logic-analyzer capture controller. After a capture completes, it reads the 1024-entry sample RAM in chronological order, starting at the capture's `start_addr` and wrapping modulo 1024. It emits the samples as a framed byte stream on a valid/ready interface to the host link (UART TX). One frame per capture: header 0xA5, 1024 sample bytes, trailer 0x5A.

## Interface
- CHN_NUM, 8, sample width in bits; legal range 1..8; bits above CHN_NUM-1 of each sample byte are sent as 0
- ADDR_W, 10, RAM address width; frame carries 2^ADDR_W samples
- iSysClk  in  1  system clock; all logic on its rising edge
- iRst  in  1  reset; asynchronous assert, active-low
- finished  in  1  one-cycle pulse from the capture controller: capture complete
- start_addr  in  ADDR_W  oldest-sample address; valid in the cycle `finished` is high
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  CHN_NUM  RAM read data; valid the cycle after `rd_en`; fixed 1-cycle latency
- tx_data  out  8  stream byte
- tx_valid  out  1  `tx_data` is valid
- tx_ready  in  1  sink accepts; a transfer occurs at a rising edge with `tx_valid` and `tx_ready` both high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse: trailer accepted
- overrun  out  1  one-cycle pulse: `finished` arrived while busy

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal state: `base` (ADDR_W), `cnt` (ADDR_W+1).
- FSM states:
  - IDLE
    - On `finished`: latch `base`=`start_addr` and `cnt`=0, then go to HEADER.
  - HEADER
    - `tx_valid`=1, `tx_data`=0xA5.
    - On transfer, go to FETCH.
  - FETCH
    - Lasts one cycle. `rd_en`=1, `rd_addr`=(`base`+`cnt`) mod 2^ADDR_W, with carry discarded. Go to WAIT.
  - WAIT
    - Lasts one cycle. Register {zeros, `rd_data`} into `tx_data`, then go to SEND.
  - SEND
    - `tx_valid`=1.
    - On transfer: if `cnt`==2^ADDR_W-1, go to TRAILER; otherwise increment `cnt` and go to FETCH.
  - TRAILER
    - `tx_valid`=1, `tx_data`=0x5A.
    - On transfer: pulse `done` and go to IDLE.
- Handshake rules:
  - Once `tx_valid` is high, it and `tx_data` stay stable until the transfer.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- `busy`=1 in every state except IDLE.
- `finished` in any state other than IDLE is ignored: `base` and `cnt` are unchanged and `overrun` pulses for one cycle.
- `rd_en` is low outside FETCH. `rd_addr` holds its last value when `rd_en` is low.
- Reset asserted mid-frame returns the block to IDLE immediately and drops all outputs to 0. No trailer is sent.

## Timing
- Latency:
  - `finished` sampled high at edge T → `busy` and `tx_valid` (header) high from T+1.
  - Header accepted at edge H → `rd_en` high in cycle H+1 → sample byte valid from H+3.
- With `tx_ready` held high, throughput is 3 cycles per sample byte. One frame takes 1 (header) + 3×1024 + 1 (trailer) = 3074 cycles from the first `tx_valid` to the `done` pulse.
- `done` is high in the cycle after the trailer transfer, simultaneous with `busy` falling.
- A `finished` pulse in the same cycle as the `done` pulse is accepted, because the state is already IDLE. Back-to-back frames therefore have no dead cycle.
- `tx_ready` stalls of any length in HEADER, SEND or TRAILER hold the state, with no RAM read issued.

## Test plan
- Reset/idle: assert `iRst`=0 mid-stream → all outputs 0 in the same cycle. Release reset, with no `finished` for 100 cycles → `tx_valid`, `rd_en` and `busy` stay 0.
- Basic frame: RAM[i]=i[7:0], `start_addr`=0, `tx_ready`=1 → stream is 0xA5, 0x00..0xFF repeated 4×, 0x5A. `done` arrives 3074 cycles after the first `tx_valid`.
- Wrap-around: `start_addr`=1020 → `rd_addr` sequence is 1020, 1021, 1022, 1023, 0, 1 … 1019. Sample bytes are 0xFC, 0xFD, 0xFE, 0xFF, 0x00 ….
- Backpressure: `tx_ready` toggled pseudo-randomly (about 30% high) → byte sequence identical to the basic frame. `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0. `rd_en` is issued exactly 1024 times.
- Overrun and width: with CHN_NUM=4, pulse `finished` twice mid-frame with `start_addr`=500 → two `overrun` pulses. The frame still starts at the original `base`. Upper nibble of every sample byte is 0.
- Back-to-back: `finished` asserted in the `done` cycle with `start_addr`=7 → second header valid on the next cycle. Its first `rd_addr` is 7.

Source files
------------

// File: rtl/capture_readout.sv
// Capture readout: walks the sample RAM from the capture's oldest entry and
// streams it as a framed byte sequence (0xA5, 2^ADDR_W samples, 0x5A) over valid/ready.
module capture_readout #(
    parameter int unsigned CHN_NUM = 8,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                iSysClk,
    input  logic                iRst,
    input  logic                finished,
    input  logic [ADDR_W-1:0]   start_addr,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [CHN_NUM-1:0]  rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ADDR_W) - 1);
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRL_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_TRAILER
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                xfer;

    assign xfer = tx_valid_q & tx_ready;

    // State and registered outputs
    always_ff @(posedge iSysClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next state; outputs are computed one cycle ahead so they leave on registers
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        overrun_d  = finished && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (finished) begin
                    base_d     = start_addr;
                    cnt_d      = '0;
                    state_d    = S_HEADER;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    state_d    = S_FETCH;
                    tx_valid_d = 1'b0;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = base_q + cnt_q[ADDR_W-1:0];
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d    = S_SEND;
                tx_valid_d = 1'b1;
                tx_data_d  = 8'(rd_data);
            end
            S_SEND: begin
                if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = S_TRAILER;
                        tx_valid_d = 1'b1;
                        tx_data_d  = TRL_BYTE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        state_d    = S_FETCH;
                        tx_valid_d = 1'b0;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = base_q + ADDR_W'(cnt_q + 1'b1);
                    end
                end
            end
            S_TRAILER: begin
                if (xfer) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
